// File: rtl/player_pkg.sv
// Shared types for the player mover: FSM state encoding and signed per-axis direction.
package player_pkg;

    typedef enum logic {
        STAY = 1'b0,
        MOVE = 1'b1
    } state_t;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_NEG  = -2'sd1;
    localparam dir_t DIR_ZERO = 2'sd0;
    localparam dir_t DIR_POS  = 2'sd1;

endpackage

// File: rtl/player_axis_step.sv
// One axis of motion: pos + dir*step evaluated at W+2 signed bits, clamped to [minPos, maxPos].
module player_axis_step
    import player_pkg::*;
#(
    parameter int W      = 10,
    parameter int STEP_W = 4
) (
    input  logic [W-1:0]      pos,
    input  dir_t              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [W-1:0]      minPos,
    input  logic [W-1:0]      maxPos,
    output logic [W-1:0]      nextPos,
    output logic              clamped
);

    logic signed [W+1:0] posS, stepS, loS, hiS, sum;

    assign posS  = $signed({2'b00, pos});
    assign stepS = $signed({{(W + 2 - STEP_W){1'b0}}, step});
    assign loS   = $signed({2'b00, minPos});
    assign hiS   = $signed({2'b00, maxPos});

    always_comb begin
        case (dir)
            DIR_POS: sum = posS + stepS;
            DIR_NEG: sum = posS - stepS;
            default: sum = posS;
        endcase
    end

    always_comb begin
        nextPos = sum[W-1:0];
        clamped = 1'b0;
        if (sum < loS) begin
            nextPos = minPos;
            clamped = 1'b1;
        end else if (sum > hiS) begin
            nextPos = maxPos;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/player_mover.sv
// Player sprite controller: synchronized buttons, STAY/MOVE FSM with speed ramp, clamped motion and registered sprite hit.
// Define PLAYER_MOVER_TRAIL_EN to build the past-position trail buffer; otherwise trail is tied to 0.
module player_mover
    import player_pkg::*;
#(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int SIZE         = 20,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 640,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 480,
    parameter int START_X      = 75,
    parameter int START_Y      = 385,
    parameter int STEP_MIN     = 4,
    parameter int STEP_MAX     = 8,
    parameter int RAMP_UPDATES = 8,
    parameter int TRAIL_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up,
    input  logic           down,
    input  logic           left,
    input  logic           right,
    input  logic           update,
    input  logic [X_W-1:0] xCount,
    input  logic [Y_W-1:0] yCount,
    output logic           player,
    output logic           trail,
    output logic [X_W-1:0] playerX,
    output logic [Y_W-1:0] playerY,
    output logic           moving,
    output logic           at_edge
);

    localparam int STEP_W = $clog2(STEP_MAX + 1);
    localparam int RAMP_W = $clog2(RAMP_UPDATES + 1);
    localparam logic [X_W-1:0] X_LO = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_HI = X_W'(X_MAX - SIZE);
    localparam logic [Y_W-1:0] Y_LO = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_HI = Y_W'(Y_MAX - SIZE);

    function automatic logic squareHit(input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                                       input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy);
        return ({1'b0, cx} > {1'b0, px}) && ({1'b0, cx} < {1'b0, px} + (X_W + 1)'(SIZE)) &&
               ({1'b0, cy} > {1'b0, py}) && ({1'b0, cy} < {1'b0, py} + (Y_W + 1)'(SIZE));
    endfunction

    // {up, down, left, right}, 1 = released
    logic [3:0] btnMeta, btnSync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnMeta <= '1;
            btnSync <= '1;
        end else begin
            btnMeta <= {up, down, left, right};
            btnSync <= btnMeta;
        end
    end

    dir_t reqDx, reqDy, dirX, dirY, axisDx, axisDy;
    logic reqIdle;

    always_comb begin
        reqDx = DIR_ZERO;
        reqDy = DIR_ZERO;
        if (!btnSync[1] && btnSync[0]) reqDx = DIR_NEG;
        else if (!btnSync[0] && btnSync[1]) reqDx = DIR_POS;
        if (!btnSync[3] && btnSync[2]) reqDy = DIR_NEG;
        else if (!btnSync[2] && btnSync[3]) reqDy = DIR_POS;
    end

    assign reqIdle = (reqDx == DIR_ZERO) && (reqDy == DIR_ZERO);

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [RAMP_W-1:0]   rampCnt;
    logic [X_W-1:0]      nextX;
    logic [Y_W-1:0]      nextY;
    logic                clampX, clampY;

    assign axisDx = (state == MOVE) ? dirX : DIR_ZERO;
    assign axisDy = (state == MOVE) ? dirY : DIR_ZERO;

    player_axis_step #(.W(X_W), .STEP_W(STEP_W)) xAxis (
        .pos(playerX), .dir(axisDx), .step(step), .minPos(X_LO), .maxPos(X_HI),
        .nextPos(nextX), .clamped(clampX)
    );

    player_axis_step #(.W(Y_W), .STEP_W(STEP_W)) yAxis (
        .pos(playerY), .dir(axisDy), .step(step), .minPos(Y_LO), .maxPos(Y_HI),
        .nextPos(nextY), .clamped(clampY)
    );

    // Move uses the state/dir from the previous update, then the request is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STAY;
            dirX    <= DIR_ZERO;
            dirY    <= DIR_ZERO;
            step    <= STEP_W'(STEP_MIN);
            rampCnt <= '0;
            playerX <= X_W'(START_X);
            playerY <= Y_W'(START_Y);
            moving  <= 1'b0;
            at_edge <= 1'b0;
        end else if (update) begin
            playerX <= nextX;
            playerY <= nextY;
            at_edge <= clampX | clampY;
            case (state)
                STAY: if (!reqIdle) state <= MOVE;
                MOVE: if (reqIdle) state <= STAY;
                default: state <= STAY;
            endcase
            moving <= !reqIdle;
            dirX   <= reqDx;
            dirY   <= reqDy;
            if (state == MOVE && reqDx == dirX && reqDy == dirY) begin
                if (rampCnt == RAMP_W'(RAMP_UPDATES - 1)) begin
                    rampCnt <= '0;
                    if (step != STEP_W'(STEP_MAX)) step <= step + 1'b1;
                end else begin
                    rampCnt <= rampCnt + 1'b1;
                end
            end else begin
                step    <= STEP_W'(STEP_MIN);
                rampCnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) player <= 1'b0;
        else     player <= squareHit(playerX, playerY, xCount, yCount);
    end

`ifdef PLAYER_MOVER_TRAIL_EN
    localparam int PTR_W = $clog2(TRAIL_DEPTH);

    logic [X_W-1:0]         trailX [TRAIL_DEPTH];
    logic [Y_W-1:0]         trailY [TRAIL_DEPTH];
    logic [TRAIL_DEPTH-1:0] trailValid;
    logic [PTR_W-1:0]       wrPtr;
    logic                   posChange, trailHit;

    assign posChange = update && ((nextX != playerX) || (nextY != playerY));

    // Pointer wraps naturally, overwriting the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trailValid <= '0;
            wrPtr      <= '0;
            trail      <= 1'b0;
            for (int i = 0; i < TRAIL_DEPTH; i++) begin
                trailX[i] <= '0;
                trailY[i] <= '0;
            end
        end else begin
            trail <= trailHit;
            if (posChange) begin
                trailX[wrPtr]     <= playerX;
                trailY[wrPtr]     <= playerY;
                trailValid[wrPtr] <= 1'b1;
                wrPtr             <= wrPtr + 1'b1;
            end
        end
    end

    always_comb begin
        trailHit = 1'b0;
        for (int i = 0; i < TRAIL_DEPTH; i++) begin
            if (trailValid[i] && squareHit(trailX[i], trailY[i], xCount, yCount)) trailHit = 1'b1;
        end
    end
`else
    assign trail = 1'b0;
`endif

endmodule
